pe_scheduler: RTL

- Sequences one PE through a complete 1-D convolution row.
- Latches a layer configuration and pulses PE_en with the packed 13-bit config word.
- Streams filter, ifmap and ipsum words from a shared single-read-port global buffer into the PE over valid/ready handshakes, then writes every opsum word back to the buffer.
- Sits between the GLB and a PE; a later revision replicates it per PE-array row.

---
 rtl/pe_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_scheduler.sv
// pe_scheduler: sequences one PE through a 1-D convolution row, streaming GLB words in and opsums back out
module pe_scheduler #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int CFG_W      = 13,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [ADDR_W-1:0] filter_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ipsum_base,
  input  logic [ADDR_W-1:0] opsum_base,
  output logic              busy,
  output logic              done,
  output logic              pe_en,
  output logic [CFG_W-1:0]  pe_config,
  output logic [DATA_W-1:0] pe_data,
  output logic              filter_valid,
  output logic              ifmap_valid,
  output logic              ipsum_valid,
  input  logic              filter_ready,
  input  logic              ifmap_ready,
  input  logic              ipsum_ready,
  input  logic [DATA_W-1:0] opsum,
  input  logic              opsum_valid,
  output logic              opsum_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_FILTER = 3'd2;
  localparam logic [2:0] S_IFMAP  = 3'd3;
  localparam logic [2:0] S_IPSUM  = 3'd4;
  localparam logic [2:0] S_OPSUM  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        r_state;
  logic [CFG_W-1:0]  r_cfg;
  logic [4:0]        r_col, r_issued, r_taken;
  logic [ADDR_W-1:0] r_if_off;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_rp, r_wp;
  logic [CW-1:0]     r_cnt;
  logic              r_inflight;

  logic [4:0]        w_rs, w_u, w_p, w_q, w_f, w_n, w_total;
  logic [ADDR_W-1:0] w_col_off, w_rd_addr;
  logic              w_rd_phase, w_valid, w_ready, w_pop, w_rd, w_wr, w_phase_end;

  assign w_rs        = 5'(r_cfg[11:10]) + 5'd1;
  assign w_u         = 5'(r_cfg[9]) + 5'd1;
  assign w_p         = 5'(r_cfg[8:7]) + 5'd1;
  assign w_f         = r_cfg[6:2];
  assign w_q         = 5'(r_cfg[1:0]) + 5'd1;
  assign w_n         = r_cfg[12] ? w_q : w_p;
  assign w_total     = r_state == S_FILTER ? w_p * w_rs :
                       r_state == S_IFMAP  ? (r_col == 5'd0 ? w_rs : w_u) : w_n;
  assign w_col_off   = ADDR_W'(r_col) * ADDR_W'(w_n);
  assign w_rd_phase  = r_state == S_FILTER || r_state == S_IFMAP || r_state == S_IPSUM;
  assign w_valid     = w_rd_phase && r_cnt != '0;
  assign w_ready     = r_state == S_FILTER ? filter_ready : r_state == S_IFMAP ? ifmap_ready : ipsum_ready;
  assign w_pop       = w_valid && w_ready;
  assign w_rd        = w_rd_phase && r_issued < w_total &&
                       (int'(r_cnt) + int'(r_inflight) - int'(w_pop)) < FIFO_DEPTH;
  assign w_wr        = r_state == S_OPSUM && opsum_valid;
  assign w_phase_end = (w_pop || w_wr) && r_taken == w_total - 5'd1;
  assign w_rd_addr   = r_state == S_FILTER ? filter_base + ADDR_W'(r_issued) :
                       r_state == S_IFMAP  ? ifmap_base + r_if_off + ADDR_W'(r_issued) :
                                             ipsum_base + w_col_off + ADDR_W'(r_issued);

  assign busy         = r_state != S_IDLE;
  assign done         = r_state == S_DONE;
  assign pe_en        = r_state == S_CFG;
  assign pe_config    = pe_en ? r_cfg : '0;
  assign pe_data      = r_mem[r_rp];
  assign filter_valid = w_valid && r_state == S_FILTER;
  assign ifmap_valid  = w_valid && r_state == S_IFMAP;
  assign ipsum_valid  = w_valid && r_state == S_IPSUM;
  assign opsum_ready  = r_state == S_OPSUM;
  assign mem_rd_en    = w_rd;
  assign mem_rd_addr  = w_rd ? w_rd_addr : '0;
  assign mem_wr_en    = w_wr;
  assign mem_wr_addr  = w_wr ? opsum_base + w_col_off + ADDR_W'(r_taken) : '0;
  assign mem_wr_data  = w_wr ? opsum : '0;

  // Row sequencing: phase counters restart at every phase boundary, column walks 0..F
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cfg    <= '0;
      r_col    <= '0;
      r_issued <= '0;
      r_taken  <= '0;
      r_if_off <= '0;
    end else begin
      r_issued <= w_phase_end ? '0 : r_issued + 5'(w_rd);
      r_taken  <= w_phase_end ? '0 : r_taken + 5'(w_pop | w_wr);
      case (r_state)
        S_IDLE: if (start) begin
          r_state  <= S_CFG;
          r_cfg    <= cfg;
          r_col    <= '0;
          r_if_off <= '0;
        end
        S_CFG:    r_state <= S_FILTER;
        S_FILTER: if (w_phase_end) r_state <= S_IFMAP;
        S_IFMAP: if (w_phase_end) begin
          r_state  <= S_IPSUM;
          r_if_off <= r_if_off + ADDR_W'(w_total);
        end
        S_IPSUM:  if (w_phase_end) r_state <= S_OPSUM;
        S_OPSUM: if (w_phase_end) begin
          r_state <= r_col == w_f ? S_DONE : S_IFMAP;
          r_col   <= r_col + 5'd1;
        end
        default:  r_state <= S_IDLE;
      endcase
    end

  // Prefetch FIFO: read data lands one cycle after the request; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rp       <= '0;
      r_wp       <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (r_inflight) r_mem[r_wp] <= mem_rd_data;
      if (r_inflight) r_wp <= r_wp == PW'(FIFO_DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == PW'(FIFO_DEPTH - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(r_inflight) - CW'(w_pop);
    end
endmodule
